branch_cond_unit: RTL and testbench

Parametrised, multi-cycle branch-condition resolver for the RV32I core. It evaluates the RISC-V B-type conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) on two XLEN-bit operands, CHUNK bits per cycle, MSB-first with early termination, and reports unconditional jumps as always taken. It sits between operand fetch and the PC-select logic. Valid/ready handshakes on both sides and a flush input let the pipeline stall or kill it mid-evaluation.

---
 rtl/branch_cond_if.sv | 25 ++
 rtl/branch_cond_unit.sv | 150 +++++++++++++++
 tb/tb_branch_cond_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_cond_if.sv
// Request/response bundle between operand fetch, the branch-condition unit and PC select.
interface branch_cond_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [2:0]      funct3;
    logic [2:0]      op_kind;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic            err;

    modport master (
        output in_valid, in_a, in_b, funct3, op_kind, out_ready,
        input  in_ready, out_valid, taken, err
    );

    modport slave (
        input  in_valid, in_a, in_b, funct3, op_kind, out_ready,
        output in_ready, out_valid, taken, err
    );
endinterface

// File: rtl/branch_cond_unit.sv
// Multi-cycle RISC-V branch-condition resolver: compares operands CHUNK bits per cycle,
// MSB chunk first, stopping at the first differing chunk.
module branch_chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             ne,
    output logic             lt
);
    assign ne = (a != b);
    assign lt = (a < b);
endmodule

module branch_cond_unit #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    branch_cond_if.slave bus
);
    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_JUMP   = 3'b100;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                   state;
    logic [IW-1:0]                idx;
    logic [NCHUNK-1:0][CHUNK-1:0] a_q;
    logic [NCHUNK-1:0][CHUNK-1:0] b_q;
    logic [2:0]                   f3_q;
    logic                         taken_q;
    logic                         err_q;

    logic [NCHUNK-1:0] ch_ne;
    logic [NCHUNK-1:0] ch_lt;
    logic              accept;
    logic              sign_fix;
    logic              cur_ne;
    logic              cur_lt;
    logic              res_eq;
    logic              res_lt;
    logic              cond;
    logic [XLEN-1:0]   a_in;
    logic [XLEN-1:0]   b_in;

    // One comparator per chunk; the active one is picked by idx.
    genvar i;
    generate
        for (i = 0; i < NCHUNK; i++) begin : g_chunk
            branch_chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
                .a  (a_q[i]),
                .b  (b_q[i]),
                .ne (ch_ne[i]),
                .lt (ch_lt[i])
            );
        end
    endgenerate

    assign cur_ne = ch_ne[idx];
    assign cur_lt = ch_lt[idx];

    assign bus.in_ready  = (state == S_IDLE) && !flush && !rst;
    assign bus.out_valid = (state == S_DONE);
    assign bus.taken     = taken_q;
    assign bus.err       = err_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Flipping the sign bit turns a signed compare into an unsigned one.
    assign sign_fix = bus.funct3[2] && !bus.funct3[1];
    assign a_in     = bus.in_a ^ (XLEN'(sign_fix) << (XLEN - 1));
    assign b_in     = bus.in_b ^ (XLEN'(sign_fix) << (XLEN - 1));

    always_comb begin
        res_eq = !cur_ne;
        res_lt = cur_ne && cur_lt;
        case (f3_q)
            3'b000:         cond = res_eq;
            3'b001:         cond = !res_eq;
            3'b100, 3'b110: cond = res_lt;
            default:        cond = !res_lt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (flush) begin
            state   <= S_IDLE;
            idx     <= '0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q  <= a_in;
                        b_q  <= b_in;
                        f3_q <= bus.funct3;
                        if (bus.op_kind == OP_JUMP) begin
                            state   <= S_DONE;
                            taken_q <= 1'b1;
                            err_q   <= 1'b0;
                        end else if (bus.op_kind != OP_BRANCH) begin
                            state   <= S_DONE;
                            taken_q <= 1'b0;
                            err_q   <= 1'b0;
                        end else if (bus.funct3[2:1] == 2'b01) begin
                            state   <= S_DONE;
                            taken_q <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            state   <= S_CMP;
                            idx     <= IDX_TOP;
                            taken_q <= 1'b0;
                            err_q   <= 1'b0;
                        end
                    end
                end
                S_CMP: begin
                    if (cur_ne || idx == '0) begin
                        state   <= S_DONE;
                        taken_q <= cond;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_cond_unit.sv
// Randomized bench for branch_cond_unit against a transaction-level reference model.
module tb_branch_cond_unit;
    localparam int XLEN   = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = XLEN / CHUNK;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    branch_cond_if #(.XLEN(XLEN)) bus ();

    branch_cond_unit #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    bit exp_ready, exp_valid, exp_taken, exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: result from plain signed/unsigned arithmetic; latency is the number of
    // chunks from the top down to and including the first differing one.
    function automatic void model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                  input logic [2:0] f3, input logic [2:0] op,
                                  output bit tk, output bit er, output int lat);
        tk = 1'b0; er = 1'b0; lat = 0;
        if (op == 3'b100) tk = 1'b1;
        else if (op != 3'b011) tk = 1'b0;
        else if (f3 == 3'b010 || f3 == 3'b011) er = 1'b1;
        else begin
            case (f3)
                3'b000:  tk = (a == b);
                3'b001:  tk = (a != b);
                3'b100:  tk = ($signed(a) < $signed(b));
                3'b101:  tk = ($signed(a) >= $signed(b));
                3'b110:  tk = (a < b);
                default: tk = (a >= b);
            endcase
            lat = NCHUNK;
            for (int i = NCHUNK - 1; i >= 0; i--) begin
                if (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) begin
                    lat = NCHUNK - i;
                    break;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", bus.in_ready, exp_ready);
            check("out_valid", bus.out_valid, exp_valid);
            if (exp_valid && bus.out_valid) begin
                check("taken", bus.taken, exp_taken);
                check("err", bus.err, exp_err);
            end
        end
    end

    // Called #1 after a rising edge with the unit idle; returns the same way after the out handshake.
    task automatic run_req(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [2:0] f3, input logic [2:0] op, input int stall);
        bit tk, er;
        int lat, n, s;
        model(a, b, f3, op, tk, er, lat);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.funct3    = f3;
        bus.op_kind   = op;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.funct3   = 3'($urandom);
        exp_ready    = 1'b0;
        exp_taken    = tk;
        exp_err      = er;
        n = 0;
        s = stall;
        forever begin
            exp_valid     = (n >= lat);
            bus.out_ready = exp_valid ? (s == 0) : 1'($urandom);
            @(posedge clk); #1;
            if (exp_valid && s == 0) break;
            if (exp_valid) s--;
            n++;
        end
        bus.out_ready = 1'b0;
        exp_valid     = 1'b0;
        exp_ready     = 1'b1;
    endtask

    initial begin
        bit tk, er;
        int lat;
        logic [XLEN-1:0] ra, rb;
        logic [2:0] rf, ro;
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.funct3 = '0; bus.op_kind = '0; bus.out_ready = 1'b0;
        exp_ready = 1'b0; exp_valid = 1'b0; exp_taken = 1'b0; exp_err = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("rst_taken", bus.taken, 0);
        check("rst_err", bus.err, 0);
        check("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0; exp_ready = 1'b1;
        @(posedge clk); #1;

        // Pin the model with hand-derived values.
        model(32'hFFFF_FFFF, 32'h1, 3'b100, 3'b011, tk, er, lat);
        check("model_blt_tk", tk, 1); check("model_blt_lat", lat, 1);
        model(32'hFFFF_FFFF, 32'h1, 3'b110, 3'b011, tk, er, lat);
        check("model_bltu_tk", tk, 0);
        model(32'h1234_5678, 32'h1234_5678, 3'b000, 3'b011, tk, er, lat);
        check("model_beq_tk", tk, 1); check("model_beq_lat", lat, 4);
        model(32'h5, 32'h5, 3'b101, 3'b011, tk, er, lat);
        check("model_bge_tk", tk, 1);
        model(32'h1, 32'h2, 3'b100, 3'b011, tk, er, lat);
        check("model_lsb_lat", lat, 4);
        model(32'h1, 32'h2, 3'b010, 3'b011, tk, er, lat);
        check("model_ill_err", er, 1); check("model_ill_lat", lat, 0);

        // Directed cases.
        run_req(32'h0, 32'h0, 3'b000, 3'b100, 0);
        run_req(32'h1234_5678, 32'h1234_5678, 3'b000, 3'b011, 0);
        run_req(32'h1234_5678, 32'h1234_5678, 3'b001, 3'b011, 0);
        run_req(32'hFFFF_FFFF, 32'h1, 3'b100, 3'b011, 0);
        run_req(32'hFFFF_FFFF, 32'h1, 3'b110, 3'b011, 0);
        run_req(32'hFFFF_FFFF, 32'h1, 3'b111, 3'b011, 0);
        run_req(32'h5, 32'h5, 3'b101, 3'b011, 3);
        run_req(32'h1, 32'h2, 3'b010, 3'b011, 0);
        run_req(32'h1, 32'h2, 3'b000, 3'b000, 1);

        // Flush in the second compare cycle: nothing delivered, taken/err cleared.
        run_req(32'h0, 32'h0, 3'b000, 3'b100, 0);
        bus.in_valid = 1'b1; bus.in_a = 32'h1; bus.in_b = 32'h2;
        bus.funct3 = 3'b100; bus.op_kind = 3'b011;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; exp_ready = 1'b0; exp_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; exp_ready = 1'b1;
        check("flush_taken", bus.taken, 0);
        check("flush_err", bus.err, 0);
        repeat (5) @(posedge clk);
        #1;

        // Flush alongside a request: it must not be accepted.
        bus.in_valid = 1'b1; bus.op_kind = 3'b100; flush = 1'b1; exp_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; flush = 1'b0; exp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a compare.
        run_req(32'h0, 32'h0, 3'b000, 3'b100, 0);
        bus.in_valid = 1'b1; bus.in_a = 32'h7; bus.in_b = 32'h7;
        bus.funct3 = 3'b000; bus.op_kind = 3'b011;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; exp_ready = 1'b0; exp_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_taken", bus.taken, 0);
        check("arst_err", bus.err, 0);
        check("arst_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0; exp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Random traffic with random gaps and backpressure.
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = ra; end
                2: begin ra = $urandom; rb = ra ^ (32'h1 << $urandom_range(0, 31)); end
                default: begin
                    ra = $urandom_range(0, 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 15));
                    rb = $urandom_range(0, 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 15));
                end
            endcase
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                7:       ro = 3'b100;
                8, 9:    ro = 3'($urandom);
                default: ro = 3'b011;
            endcase
            repeat ($urandom_range(0, 2)) begin
                bus.in_a = $urandom;
                @(posedge clk); #1;
            end
            run_req(ra, rb, rf, ro, $urandom_range(0, 3));
        end

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
